mfic_deframer: RTL and testbench

MFIC_DEFRAMER -- requirements
Module: mfic_deframer

---
 rtl/mfic_pkg.sv | 18 +
 rtl/mfic_csum.sv | 24 ++
 rtl/mfic_deframer.sv | 122 ++++++++++++
 tb/tb_mfic_deframer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfic_pkg.sv
// Shared definitions for the MFIC frame deframer: FSM states, default sync word
// and header field layout.
package mfic_pkg;

    typedef enum logic [1:0] {
        HUNT,
        HDR,
        DATA,
        CHK
    } mfic_state_t;

    localparam logic [31:0] SYNC_DEFAULT = 32'hA5A5_5A5A;

    // Azimuth occupies the low half of the header word; the upper half is ignored.
    localparam int unsigned AZ_LSB = 0;
    localparam int unsigned AZ_W   = 16;

endpackage

// File: rtl/mfic_csum.sv
// Frame checksum accumulator: modulo-2^WIDTH running sum of header and channel words.
module mfic_csum #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_10,
    input  logic             reset_b,
    input  logic             clear,
    input  logic             add,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] value
);

    // clear seeds the sum with din (the header) rather than zero
    always_ff @(posedge clk_10 or negedge reset_b) begin
        if (!reset_b) begin
            value <= '0;
        end else if (clear) begin
            value <= din;
        end else if (add) begin
            value <= value + din;
        end
    end

endmodule

// File: rtl/mfic_deframer.sv
// MFIC deframer: hunts for SYNC, collects header + N_CH channel words, verifies the
// checksum and publishes the frame atomically; an idle watchdog aborts stalled frames.
module mfic_deframer
    import mfic_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      N_CH    = 16,
    parameter logic [WIDTH-1:0] SYNC    = WIDTH'(SYNC_DEFAULT),
    parameter int unsigned      TIMEOUT = 64
) (
    input  logic                  clk_10,
    input  logic                  reset_b,
    input  logic [WIDTH-1:0]      sig_in,
    input  logic                  ena_in,
    output logic [N_CH*WIDTH-1:0] ch_data,
    output logic [15:0]           azimuth,
    output logic                  strobe,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt
);

    localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mfic_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [IDLE_W-1:0] idle_cnt;
    logic [AZ_W-1:0]   hdr_az;
    logic [WIDTH-1:0]  shadow [N_CH];
    logic [WIDTH-1:0]  acc;
    logic              csum_clear;
    logic              csum_add;

    always_comb begin
        csum_clear = ena_in && (state == HDR);
        csum_add   = ena_in && (state == DATA);
    end

    mfic_csum #(
        .WIDTH (WIDTH)
    ) u_csum (
        .clk_10  (clk_10),
        .reset_b (reset_b),
        .clear   (csum_clear),
        .add     (csum_add),
        .din     (sig_in),
        .value   (acc)
    );

    always_ff @(posedge clk_10 or negedge reset_b) begin
        if (!reset_b) begin
            state     <= HUNT;
            idx       <= '0;
            idle_cnt  <= '0;
            hdr_az    <= '0;
            ch_data   <= '0;
            azimuth   <= '0;
            strobe    <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            strobe    <= 1'b0;
            frame_err <= 1'b0;
            if (state != HUNT && !ena_in) begin
                if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                    frame_err <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                    idle_cnt <= '0;
                    state    <= HUNT;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else if (ena_in) begin
                idle_cnt <= '0;
                case (state)
                    HUNT: begin
                        if (sig_in == SYNC) begin
                            state <= HDR;
                        end
                    end
                    HDR: begin
                        hdr_az <= sig_in[AZ_LSB +: AZ_W];
                        idx    <= '0;
                        state  <= DATA;
                    end
                    DATA: begin
                        shadow[idx] <= sig_in;
                        if (idx == IDX_W'(N_CH - 1)) begin
                            state <= CHK;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    CHK: begin
                        if (sig_in == acc) begin
                            for (int unsigned k = 0; k < N_CH; k++) begin
                                ch_data[k*WIDTH +: WIDTH] <= shadow[k];
                            end
                            azimuth   <= hdr_az;
                            strobe    <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 16'd1;
                            end
                        end
                        state <= HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mfic_deframer.sv
// Self-checking bench for mfic_deframer: directed vector table, hand-written corner
// sequences and randomized traffic, all compared every cycle against a frame-level model.
module tb_mfic_deframer;

    localparam int          W   = 32;
    localparam int          NC  = 16;
    localparam int          TO  = 64;
    localparam int          CW  = NC * W;
    localparam logic [31:0] SYN = 32'hA5A5_5A5A;

    logic          clk_10 = 1'b0;
    logic          reset_b;
    logic [W-1:0]  sig_in;
    logic          ena_in;
    logic [CW-1:0] ch_data;
    logic [15:0]   azimuth;
    logic          strobe;
    logic          frame_err;
    logic [15:0]   frame_cnt;
    logic [15:0]   err_cnt;

    mfic_deframer #(
        .WIDTH   (W),
        .N_CH    (NC),
        .SYNC    (SYN),
        .TIMEOUT (TO)
    ) dut (
        .clk_10    (clk_10),
        .reset_b   (reset_b),
        .sig_in    (sig_in),
        .ena_in    (ena_in),
        .ch_data   (ch_data),
        .azimuth   (azimuth),
        .strobe    (strobe),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #50 clk_10 = ~clk_10;

    int n_checks = 0;
    int n_errors = 0;
    int obs_strobe;
    int obs_err;

    // Frame-level reference model: words of the current frame are queued and the
    // checksum is evaluated by summing the queue once the frame is complete.
    bit            m_in;
    logic [31:0]   m_fw [$];
    int            m_idle;
    logic [CW-1:0] m_ch;
    logic [15:0]   m_az, m_fc, m_ec;
    bit            m_strobe, m_err;

    logic [31:0]   tx [$];

    typedef struct {
        bit          rst;
        logic [31:0] hdr;
        logic [31:0] base;
        logic [31:0] xr;
        int          gap;
        bit          good;
        logic [15:0] az;
        logic [31:0] ch15;
        logic [15:0] fc;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_v(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_fw.delete(); m_idle = 0;
        m_ch = '0; m_az = '0; m_fc = '0; m_ec = '0;
        m_strobe = 0; m_err = 0;
    endtask

    task automatic model_step(input bit e, input logic [31:0] w);
        logic [31:0] s;
        m_strobe = 0;
        m_err    = 0;
        if (e) begin
            if (!m_in) begin
                if (w == SYN) begin
                    m_in = 1; m_fw.delete(); m_idle = 0;
                end
            end else begin
                m_fw.push_back(w);
                m_idle = 0;
                if (m_fw.size() == NC + 2) begin
                    s = '0;
                    for (int i = 0; i <= NC; i++) s += m_fw[i];
                    if (s == w) begin
                        m_strobe = 1;
                        m_az     = m_fw[0][15:0];
                        for (int k = 0; k < NC; k++) m_ch[k*W +: W] = m_fw[k+1];
                        m_fc++;
                    end else begin
                        m_err = 1;
                        if (m_ec != 16'hFFFF) m_ec++;
                    end
                    m_in = 0;
                end
            end
        end else if (m_in) begin
            m_idle++;
            if (m_idle == TO) begin
                m_err = 1;
                if (m_ec != 16'hFFFF) m_ec++;
                m_in = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("strobe", 32'(strobe), 32'(m_strobe));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("azimuth", 32'(azimuth), 32'(m_az));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        chk("err_cnt", 32'(err_cnt), 32'(m_ec));
        chk_v("ch_data", ch_data, m_ch);
    endtask

    task automatic cycle(input bit e, input logic [31:0] w);
        ena_in = e;
        sig_in = w;
        @(posedge clk_10);
        #1;
        model_step(e, w);
        compare_all();
        if (strobe)    obs_strobe++;
        if (frame_err) obs_err++;
        ena_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom());
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        ena_in  = 1'b0;
        sig_in  = '0;
        #7;
        model_reset();
        compare_all();
        @(posedge clk_10);
        #10;
        reset_b = 1'b1;
        #1;
    endtask

    task automatic build_frame(input logic [31:0] hdr, input logic [31:0] base,
                               input bit rnd, input logic [31:0] xr);
        logic [31:0] s, w;
        tx.delete();
        tx.push_back(SYN);
        tx.push_back(hdr);
        s = hdr;
        for (int k = 0; k < NC; k++) begin
            w = rnd ? $urandom() : base + 32'(k);
            tx.push_back(w);
            s += w;
        end
        tx.push_back(s ^ xr);
    endtask

    // gap < 0 picks a random gap per word, occasionally long enough to hit the watchdog
    task automatic send_range(input int lo, input int hi, input int gap);
        int g;
        for (int i = lo; i <= hi; i++) begin
            if (i > lo) begin
                if (gap >= 0) g = gap;
                else if ($urandom_range(0, 15) == 0) g = int'($urandom_range(60, 66));
                else g = int'($urandom_range(0, 2));
                idle(g);
            end
            cycle(1'b1, tx[i]);
        end
    endtask

    initial begin
        reset_b = 1'b0;
        ena_in  = 1'b0;
        sig_in  = '0;
        model_reset();

        tbl[0] = '{1'b1, 32'h0000_0064, 32'h1,         32'h0,  0, 1'b1, 16'd100,  32'h10,        16'd1, 16'd0};
        tbl[1] = '{1'b1, 32'h0000_0064, 32'h1,         32'h31, 0, 1'b0, 16'd0,    32'h0,         16'd0, 16'd1};
        tbl[2] = '{1'b1, 32'h0000_0064, 32'h1,         32'h0,  5, 1'b1, 16'd100,  32'h10,        16'd1, 16'd0};
        tbl[3] = '{1'b0, 32'hBEEF_1234, 32'hFFFF_FFF0, 32'h0,  1, 1'b1, 16'h1234, 32'hFFFF_FFFF, 16'd2, 16'd0};
        tbl[4] = '{1'b0, SYN,           SYN,           32'h0,  0, 1'b1, 16'h5A5A, 32'hA5A5_5A69, 16'd3, 16'd0};
        tbl[5] = '{1'b0, 32'h0000_0064, 32'h1,         32'h1,  2, 1'b0, 16'h5A5A, 32'hA5A5_5A69, 16'd3, 16'd1};

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].rst) do_reset();
            build_frame(tbl[i].hdr, tbl[i].base, 1'b0, tbl[i].xr);
            obs_strobe = 0;
            obs_err    = 0;
            send_range(0, NC + 2, tbl[i].gap);
            idle(2);
            chk($sformatf("vec%0d strobe_pulses", i), 32'(obs_strobe), 32'(tbl[i].good));
            chk($sformatf("vec%0d err_pulses", i), 32'(obs_err), 32'(!tbl[i].good));
            chk($sformatf("vec%0d azimuth", i), 32'(azimuth), 32'(tbl[i].az));
            chk($sformatf("vec%0d ch15", i), ch_data[15*W +: W], tbl[i].ch15);
            chk($sformatf("vec%0d frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].fc));
            chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].ec));
        end

        // Stall after channel 7 for the full timeout, then a clean frame
        do_reset();
        build_frame(32'h64, 32'h1, 1'b0, 32'h0);
        obs_strobe = 0; obs_err = 0;
        send_range(0, 9, 0);
        idle(TO);
        chk("timeout err_pulses", 32'(obs_err), 32'd1);
        chk("timeout err_cnt", 32'(err_cnt), 32'd1);
        obs_strobe = 0; obs_err = 0;
        send_range(0, NC + 2, 0);
        idle(1);
        chk("after_timeout strobe_pulses", 32'(obs_strobe), 32'd1);
        chk("after_timeout frame_cnt", 32'(frame_cnt), 32'd1);

        // One cycle short of the timeout must not abort the frame
        do_reset();
        obs_strobe = 0; obs_err = 0;
        send_range(0, 9, 0);
        idle(TO - 1);
        send_range(10, NC + 2, 0);
        idle(1);
        chk("near_timeout err_pulses", 32'(obs_err), 32'd0);
        chk("near_timeout strobe_pulses", 32'(obs_strobe), 32'd1);

        // Garbage, then two frames back to back
        do_reset();
        obs_strobe = 0; obs_err = 0;
        cycle(1'b1, 32'h1111_1111);
        cycle(1'b1, 32'h2222_2222);
        cycle(1'b1, 32'h3333_3333);
        send_range(0, NC + 2, 0);
        build_frame(32'h0000_00C8, 32'h100, 1'b0, 32'h0);
        send_range(0, NC + 2, 0);
        idle(1);
        chk("b2b strobe_pulses", 32'(obs_strobe), 32'd2);
        chk("b2b frame_cnt", 32'(frame_cnt), 32'd2);
        chk("b2b azimuth", 32'(azimuth), 32'd200);

        // Reset in the middle of a frame, then a clean frame
        do_reset();
        build_frame(32'h64, 32'h1, 1'b0, 32'h0);
        obs_strobe = 0; obs_err = 0;
        send_range(0, 5, 0);
        do_reset();
        send_range(0, NC + 2, 0);
        idle(1);
        chk("midreset err_pulses", 32'(obs_err), 32'd0);
        chk("midreset frame_cnt", 32'(frame_cnt), 32'd1);
        chk("midreset err_cnt", 32'(err_cnt), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int it = 0; it < 80; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 1) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) cycle(1'b1, $urandom());
            end else if (r <= 7) begin
                build_frame($urandom(), 32'h0, 1'b1, (r >= 6) ? ($urandom() | 32'h1) : 32'h0);
                send_range(0, NC + 2, -1);
            end else if (r == 8) begin
                build_frame($urandom(), 32'h0, 1'b1, 32'h0);
                send_range(0, int'($urandom_range(1, NC + 1)), -1);
                idle(int'($urandom_range(TO - 1, TO + 2)));
            end else begin
                build_frame($urandom(), 32'h0, 1'b1, 32'h0);
                send_range(0, int'($urandom_range(0, NC + 1)), -1);
                do_reset();
            end
            idle(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
